// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
// Shares one single-bit SPI memory (mode 0, 0x03 READ / 0x02 WRITE, 24-bit
// address) between the instruction-fetch port (16-bit word reads) and the
// data port (8-bit reads/writes). Round-robin arbitration in IDLE, then the
// full CS/SCLK/MOSI/MISO sequence for the winner.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   if_req/if_addr             fetch request and word address
//   if_rdata/if_ready          fetched word (big-endian) and completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, write enable, byte address, data
//   d_rdata/d_ready            read byte and completion pulse
//   spi_cs_n/spi_sclk          chip select (active low), SPI clock (idle low)
//   spi_mosi/spi_mosi_oe       io0 data and its output enable
//   spi_miso                   io1 data from memory
//   busy                       high whenever the FSM is not in IDLE
//
// Handshake: a requester raises req with its address/we/wdata and holds them
// until its ready pulse. Everything is latched at grant, so later changes are
// ignored; dropping req after grant does not cancel the transaction. A req
// still high in the IDLE cycle after ready is a new request.
module spi_mem_arbiter #(
  parameter int unsigned CLK_DIV   = 1,
  parameter logic [23:0] IF_BASE   = 24'h000000,
  parameter logic [23:0] DATA_BASE = 24'h010000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [7:0]  d_wdata,
  output logic [7:0]  d_rdata,
  output logic        d_ready,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_mosi_oe,
  input  logic        spi_miso,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Phase counter runs 0 .. 2*CLK_DIV-1 within one bit: low half, then high half.
  localparam int unsigned PH_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);

  logic [2:0]      state;
  logic [PH_W-1:0] ph;
  logic [5:0]      bit_cnt;
  logic [47:0]     tx_sr;
  logic [15:0]     rx_sr;
  logic            cur_fetch;
  logic            cur_we;
  logic            last_grant_data;

  logic            in_bits;
  logic            bit_end;
  logic [5:0]      last_bit;
  logic            grant_if;
  logic            grant_d;
  logic [23:0]     fetch_addr;
  logic [23:0]     data_addr;

  assign in_bits  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
  assign bit_end  = in_bits && (ph == PH_LAST);
  assign last_bit = cur_fetch ? 6'd47 : 6'd39;

  // On a tie the port that did not win last time goes first.
  assign grant_if = if_req && (!d_req || last_grant_data);
  assign grant_d  = d_req && !grant_if;

  // 24-bit sums wrap silently.
  assign fetch_addr = IF_BASE + {7'b0, if_addr, 1'b0};
  assign data_addr  = DATA_BASE + {16'b0, d_addr};

  assign spi_cs_n    = !in_bits;
  assign spi_sclk    = in_bits && (ph >= PH_HIGH);
  assign spi_mosi_oe = (state == S_CMD) || (state == S_ADDR) || ((state == S_DATA) && cur_we);
  assign spi_mosi    = spi_mosi_oe && tx_sr[47];
  assign if_ready    = (state == S_DONE) && cur_fetch;
  assign d_ready     = (state == S_DONE) && !cur_fetch;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      ph              <= '0;
      bit_cnt         <= '0;
      tx_sr           <= '0;
      rx_sr           <= '0;
      cur_fetch       <= 1'b0;
      cur_we          <= 1'b0;
      last_grant_data <= 1'b1;
      if_rdata        <= '0;
      d_rdata         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_if || grant_d) begin
            state           <= S_CMD;
            ph              <= '0;
            bit_cnt         <= '0;
            cur_fetch       <= grant_if;
            cur_we          <= grant_d && d_we;
            last_grant_data <= grant_d;
            // Whole frame preloaded MSB first: command, address, write byte.
            if (grant_if) tx_sr <= {8'h03, fetch_addr, 16'h0000};
            else          tx_sr <= {(d_we ? 8'h02 : 8'h03), data_addr, d_wdata, 8'h00};
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          // MISO is taken on the edge where SCLK goes high.
          if ((state == S_DATA) && (ph == PH_RISE)) rx_sr <= {rx_sr[14:0], spi_miso};
          if (bit_end) begin
            ph      <= '0;
            tx_sr   <= {tx_sr[46:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == last_bit) begin
              state <= S_DONE;
              // Results become visible in DONE, alongside the ready pulse.
              if (cur_fetch)    if_rdata <= rx_sr;
              else if (!cur_we) d_rdata  <= rx_sr[7:0];
            end else if (bit_cnt == 6'd7) begin
              state <= S_ADDR;
            end else if (bit_cnt == 6'd31) begin
              state <= S_DATA;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: two instances (CLK_DIV=1 with default bases,
// CLK_DIV=3 with IF_BASE near the top of the address space), each with its
// own SPI memory slave and a cycle-level expectation derived from the bit
// timing rules: a grant in cycle t occupies cycles t+1 .. t+2*CD*N with one
// bit per 2*CD cycles, followed by one DONE cycle.
module tb_spi_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  logic        if_req_a    [2];
  logic [15:0] if_addr_a   [2];
  logic [15:0] if_rdata_a  [2];
  logic        if_ready_a  [2];
  logic        d_req_a     [2];
  logic        d_we_a      [2];
  logic [7:0]  d_addr_a    [2];
  logic [7:0]  d_wdata_a   [2];
  logic [7:0]  d_rdata_a   [2];
  logic        d_ready_a   [2];
  logic        cs_n_a      [2];
  logic        sclk_a      [2];
  logic        mosi_a      [2];
  logic        oe_a        [2];
  logic        miso_a      [2];
  logic        busy_a      [2];

  // Shared backing store; unwritten bytes read as a fixed address pattern.
  logic [7:0] mem [int];

  int checks   = 0;
  int failures = 0;

  int  rdy_log [$];
  logic log_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ 8'hC3;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- DUTs, slaves, models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int          CD  = (g == 0) ? 1 : 3;
    localparam logic [23:0] IFB = (g == 0) ? 24'h000000 : 24'hFFFFFE;
    localparam logic [23:0] DB  = 24'h010000;

    spi_mem_arbiter #(.CLK_DIV(CD), .IF_BASE(IFB), .DATA_BASE(DB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req      (if_req_a[g]),
      .if_addr     (if_addr_a[g]),
      .if_rdata    (if_rdata_a[g]),
      .if_ready    (if_ready_a[g]),
      .d_req       (d_req_a[g]),
      .d_we        (d_we_a[g]),
      .d_addr      (d_addr_a[g]),
      .d_wdata     (d_wdata_a[g]),
      .d_rdata     (d_rdata_a[g]),
      .d_ready     (d_ready_a[g]),
      .spi_cs_n    (cs_n_a[g]),
      .spi_sclk    (sclk_a[g]),
      .spi_mosi    (mosi_a[g]),
      .spi_mosi_oe (oe_a[g]),
      .spi_miso    (miso_a[g]),
      .busy        (busy_a[g])
    );

    // SPI memory slave: shifts MOSI on SCLK rise, drives MISO after SCLK fall.
    int          bitn  = 0;
    int          s_bits = 0;
    int          s_oe  = 0;
    logic [47:0] sh    = '0;
    logic [7:0]  s_cmd = '0;
    logic [23:0] s_addr = '0;
    logic [7:0]  s_wdata = '0;

    always @(posedge sclk_a[g] or posedge cs_n_a[g]) begin
      if (cs_n_a[g]) begin
        if (bitn != 0) s_bits = bitn;
        bitn = 0;
      end else begin
        if (bitn == 0) s_oe = 0;
        if (oe_a[g]) s_oe++;
        sh = {sh[46:0], mosi_a[g]};
        bitn++;
        if (bitn == 32) begin
          s_cmd  = sh[31:24];
          s_addr = sh[23:0];
        end
        if (bitn == 40 && s_cmd == 8'h02) begin
          s_wdata = sh[7:0];
          mem[int'(s_addr)] = sh[7:0];
        end
      end
    end

    always @(negedge sclk_a[g]) begin : slave_out
      logic [7:0] b;
      if (!cs_n_a[g] && s_cmd == 8'h03 && bitn >= 32 && bitn < 48) begin
        b = mem_rd(s_addr + 24'((bitn - 32) / 8));
        miso_a[g] = b[7 - ((bitn - 32) % 8)];
      end else begin
        miso_a[g] = 1'b0;
      end
    end

    // Expected outputs, one compare per cycle on the falling clock edge.
    logic        m_act  = 1'b0;
    logic        m_port = 1'b0;   // 0 = fetch, 1 = data
    logic        m_we   = 1'b0;
    logic        m_last = 1'b1;
    int          k      = 0;
    int          nb     = 0;
    logic [47:0] m_stream = '0;
    logic [15:0] m_rd   = '0;
    logic [15:0] e_if   = '0;
    logic [7:0]  e_d    = '0;

    always @(negedge clk) begin : model
      logic [6:0]  pins;   // {busy, cs_n, sclk, oe, mosi, if_ready, d_ready}
      logic [6:0]  exp_p;
      logic [23:0] a;
      int          bi, ph;
      logic        oe;
      pins = {busy_a[g], cs_n_a[g], sclk_a[g], oe_a[g], mosi_a[g], if_ready_a[g], d_ready_a[g]};
      exp_p = 7'b0100000;
      if (!rst_n) begin
        m_act = 1'b0; m_last = 1'b1; e_if = '0; e_d = '0;
      end else if (!m_act) begin
        if (if_req_a[g] || d_req_a[g]) begin
          m_port = (if_req_a[g] && d_req_a[g]) ? !m_last : d_req_a[g];
          m_last = m_port;
          m_act  = 1'b1;
          k      = 0;
          if (!m_port) begin
            a = IFB + {7'b0, if_addr_a[g], 1'b0};
            m_we = 1'b0; nb = 48;
            m_stream = {8'h03, a, 16'h0000};
            m_rd = {mem_rd(a), mem_rd(a + 24'd1)};
          end else begin
            a = DB + {16'b0, d_addr_a[g]};
            m_we = d_we_a[g]; nb = 40;
            m_stream = {(m_we ? 8'h02 : 8'h03), a, d_wdata_a[g], 8'h00};
            m_rd = {8'h00, mem_rd(a)};
          end
        end
      end else begin
        k++;
        if (k <= 2 * CD * nb) begin
          bi = (k - 1) / (2 * CD);
          ph = (k - 1) % (2 * CD);
          oe = (bi < 32) || m_we;
          exp_p = {1'b1, 1'b0, (ph >= CD), oe, oe & m_stream[47 - bi], 2'b00};
        end else begin
          exp_p = {1'b1, 1'b1, 3'b000, !m_port, m_port};
          if (!m_port)   e_if = m_rd;
          else if (!m_we) e_d = m_rd[7:0];
          m_act = 1'b0;
        end
      end
      chk($sformatf("pins%0d k=%0d", g, k), {41'b0, pins}, {41'b0, exp_p});
      chk($sformatf("if_rdata%0d", g), {32'b0, if_rdata_a[g]}, {32'b0, e_if});
      chk($sformatf("d_rdata%0d", g), {40'b0, d_rdata_a[g]}, {40'b0, e_d});
    end
  end

  always @(negedge clk) begin
    if (log_en) begin
      if (if_ready_a[0]) rdy_log.push_back(0);
      if (d_ready_a[0])  rdy_log.push_back(1);
    end
  end

  // ---------------- driver ----------------
  task automatic xact(input int i, input bit is_data, input bit we, input logic [15:0] a,
                      input logic [7:0] wd, input bit drop, output int lat);
    int  t0;
    bit  got;
    got = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    if (is_data) begin
      d_we_a[i] = we; d_addr_a[i] = a[7:0]; d_wdata_a[i] = wd; d_req_a[i] = 1'b1;
    end else begin
      if_addr_a[i] = a; if_req_a[i] = 1'b1;
    end
    t0 = cyc;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (drop && n == 10) begin
        if (is_data) d_req_a[i] = 1'b0; else if_req_a[i] = 1'b0;
      end
      @(negedge clk);
      if ((is_data && d_ready_a[i]) || (!is_data && if_ready_a[i])) begin
        got = 1'b1;
        lat = cyc - t0;
        break;
      end
    end
    if (!got) chk("ready_timeout", 48'd0, 48'd1);
    @(posedge clk); #1;
    if (is_data) d_req_a[i] = 1'b0; else if_req_a[i] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int lat, lat_f, lat_d;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if_req_a[i] = 1'b0; if_addr_a[i] = '0;
      d_req_a[i] = 1'b0; d_we_a[i] = 1'b0; d_addr_a[i] = '0; d_wdata_a[i] = '0;
    end
    mem[32'h000024] = 8'hA5;
    mem[32'h000025] = 8'h3C;
    mem[32'h000000] = 8'h12;
    mem[32'h000001] = 8'h34;

    // Both ports requesting from reset: grants must alternate, fetch first.
    if_addr_a[0] = 16'h0012; if_req_a[0] = 1'b1;
    d_addr_a[0]  = 8'h07; d_we_a[0] = 1'b0; d_req_a[0] = 1'b1;
    log_en = 1'b1;
    #1;
    chk("reset_cs_n", {47'b0, cs_n_a[0]}, 48'd1);
    chk("reset_busy", {47'b0, busy_a[0]}, 48'd0);
    chk("reset_if_rdata", {32'b0, if_rdata_a[0]}, 48'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk); #1;
      if (rdy_log.size() >= 4) break;
    end
    @(posedge clk); #1;
    if_req_a[0] = 1'b0; d_req_a[0] = 1'b0; log_en = 1'b0;
    if (rdy_log.size() < 4) chk("alternation_timeout", 48'(rdy_log.size()), 48'd4);
    else for (int n = 0; n < 4; n++)
      chk($sformatf("grant_order[%0d]", n), 48'(rdy_log[n]), 48'(n % 2));
    chk("alt_if_rdata", {32'b0, if_rdata_a[0]}, 48'hA53C);
    chk("alt_d_rdata", {40'b0, d_rdata_a[0]}, 48'hC4);
    repeat (3) @(posedge clk);

    // Fetch word 0x0012 -> bytes 0x24/0x25.
    xact(0, 1'b0, 1'b0, 16'h0012, 8'h00, 1'b0, lat);
    chk("fetch_latency", 48'(lat), 48'd97);
    chk("fetch_rdata", {32'b0, if_rdata_a[0]}, 48'hA53C);
    chk("fetch_cmd", {40'b0, g_inst[0].s_cmd}, 48'h03);
    chk("fetch_addr", {24'b0, g_inst[0].s_addr}, 48'h000024);
    chk("fetch_sclk_edges", 48'(g_inst[0].s_bits), 48'd48);

    // Data write then read back.
    xact(0, 1'b1, 1'b1, 16'h0007, 8'h5E, 1'b0, lat);
    chk("write_latency", 48'(lat), 48'd81);
    chk("write_cmd", {40'b0, g_inst[0].s_cmd}, 48'h02);
    chk("write_addr", {24'b0, g_inst[0].s_addr}, 48'h010007);
    chk("write_data", {40'b0, g_inst[0].s_wdata}, 48'h5E);
    chk("write_oe_bits", 48'(g_inst[0].s_oe), 48'd40);
    chk("write_mem", {40'b0, mem_rd(24'h010007)}, 48'h5E);
    xact(0, 1'b1, 1'b0, 16'h0007, 8'h00, 1'b0, lat);
    chk("read_latency", 48'(lat), 48'd81);
    chk("read_rdata", {40'b0, d_rdata_a[0]}, 48'h5E);
    chk("read_oe_bits", 48'(g_inst[0].s_oe), 48'd32);
    chk("read_if_hold", {32'b0, if_rdata_a[0]}, 48'hA53C);

    // Request withdrawn after grant still completes.
    xact(0, 1'b0, 1'b0, 16'h0013, 8'h00, 1'b1, lat);
    chk("drop_latency", 48'(lat), 48'd97);
    chk("drop_rdata", {32'b0, if_rdata_a[0]}, 48'hE5E4);

    // Reset in the middle of the address phase.
    @(posedge clk); #1;
    if_addr_a[0] = 16'h0012; if_req_a[0] = 1'b1;
    repeat (25) @(posedge clk);
    #2 chk("pre_abort_cs_n", {47'b0, cs_n_a[0]}, 48'd0);
    #1 rst_n = 1'b0; if_req_a[0] = 1'b0;
    #1;
    chk("abort_cs_n", {47'b0, cs_n_a[0]}, 48'd1);
    chk("abort_sclk", {47'b0, sclk_a[0]}, 48'd0);
    chk("abort_busy", {47'b0, busy_a[0]}, 48'd0);
    chk("abort_d_rdata", {40'b0, d_rdata_a[0]}, 48'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    xact(0, 1'b0, 1'b0, 16'h0012, 8'h00, 1'b0, lat);
    chk("post_abort_latency", 48'(lat), 48'd97);
    chk("post_abort_rdata", {32'b0, if_rdata_a[0]}, 48'hA53C);

    // Random concurrent traffic on both ports.
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          xact(0, 1'b0, 1'b0, 16'($urandom_range(0, 65535)), 8'h00, 1'b0, lat_f);
        end
      end
      begin
        for (int n = 0; n < 16; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          xact(0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), 1'b0, lat_d);
        end
      end
    join

    // CLK_DIV=3 instance; base 0xFFFFFE + 2 wraps to address 0.
    xact(1, 1'b0, 1'b0, 16'h0001, 8'h00, 1'b0, lat);
    chk("cd3_latency", 48'(lat), 48'd289);
    chk("cd3_rdata", {32'b0, if_rdata_a[1]}, 48'h1234);
    chk("cd3_wrap_addr", {24'b0, g_inst[1].s_addr}, 48'h000000);
    chk("cd3_sclk_edges", 48'(g_inst[1].s_bits), 48'd48);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
